// File: rtl/config_access_pkg.sv
// config_access_pkg: shared state encoding and sizing helper for the config export BEL
package config_access_pkg;

    typedef enum logic {
        CA_IDLE,
        CA_SHIFT
    } ca_state_t;

    function automatic int ca_cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/config_serialiser.sv
// config_serialiser: snapshots a word and shifts it out one bit per cycle
module config_serialiser
    import config_access_pkg::*;
#(
    parameter int W         = 12,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] din,
    output logic         rd_data,
    output logic         rd_valid,
    output logic         rd_last,
    output logic         busy
);

    localparam int CW = ca_cnt_w(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    ca_state_t     state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  snap;

    // Frame FSM: a start is only honoured in IDLE; the snapshot is shifted so the output tap is fixed
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CA_IDLE;
            cnt      <= '0;
            snap     <= '0;
            rd_data  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
        end else if (state == CA_IDLE) begin
            rd_data  <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (start) begin
                snap  <= din;
                cnt   <= '0;
                state <= CA_SHIFT;
                busy  <= 1'b1;
            end
        end else begin
            rd_valid <= 1'b1;
            rd_data  <= MSB_FIRST ? snap[W-1] : snap[0];
            snap     <= MSB_FIRST ? snap << 1 : snap >> 1;
            rd_last  <= cnt == LAST;
            cnt      <= cnt == LAST ? '0 : cnt + 1'b1;
            state    <= cnt == LAST ? CA_IDLE : CA_SHIFT;
            busy     <= cnt != LAST;
        end
    end

endmodule

// File: rtl/config_access_shadow.sv
// config_access_shadow: handshake-updated shadow of tile config bits with serial readback
(* FABulous, BelMap, INIT=0, INIT_1=1, INIT_2=2, INIT_3=3, INIT_4=4, INIT_5=5, INIT_6=6, INIT_7=7, INIT_8=8, INIT_9=9, INIT_10=10, INIT_11=11 *)
module config_access_shadow
    import config_access_pkg::*;
#(
    parameter int                      NoConfigBits = 12,
    parameter logic [NoConfigBits-1:0] RESET_VALUE  = '0,
    parameter bit                      AUTO_UPDATE  = 1'b0,
    parameter bit                      MSB_FIRST    = 1'b0
) (
    input  logic                                         UserCLK,
    input  logic                                         RESET,
    (* FABulous, GLOBAL *)   input  logic [NoConfigBits-1:0] ConfigBits,
    (* FABulous, EXTERNAL *) output logic [NoConfigBits-1:0] C_bits,
    input  logic                                         update_req,
    output logic                                         update_ack,
    output logic                                         changed,
    input  logic                                         rd_start,
    output logic                                         rd_data,
    output logic                                         rd_valid,
    output logic                                         rd_last,
    output logic                                         busy
);

    logic load;

    assign load = AUTO_UPDATE || update_req;

    // Shadow register: level-sensitive capture, ack and change flag registered one cycle behind
    always_ff @(posedge UserCLK) begin
        if (RESET) begin
            C_bits     <= RESET_VALUE;
            update_ack <= 1'b0;
            changed    <= 1'b0;
        end else begin
            if (load) C_bits <= ConfigBits;
            update_ack <= !AUTO_UPDATE && update_req;
            changed    <= load && (ConfigBits != C_bits);
        end
    end

    config_serialiser #(
        .W         (NoConfigBits),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk      (UserCLK),
        .rst      (RESET),
        .start    (rd_start),
        .din      (C_bits),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (busy)
    );

endmodule

// File: tb/tb_config_access_shadow.sv
// tb_config_access_shadow: scoreboard bench for shadow updates, readback framing and auto mode
module tb_config_access_shadow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] cfg = 12'hA5A;
    logic [11:0] cfg2 = 12'hA5A;
    logic        update_req = 1'b0;
    logic        rd_start = 1'b0;

    logic [11:0] c0, c1, c2;
    logic        ack0, chg0, d0, v0, l0, b0;
    logic        ack1, chg1, d1, v1, l1, b1;
    logic        ack2, chg2, d2, v2, l2, b2;

    int n_pass = 0;
    int n_tot  = 0;

    logic [1:0]  q0[$];
    logic [1:0]  q1[$];
    logic [12:0] ack_q[$];
    logic [11:0] auto_q[$];

    always #5 clk = ~clk;

    config_access_shadow #(.NoConfigBits(12), .RESET_VALUE(12'hA5A), .AUTO_UPDATE(1'b0), .MSB_FIRST(1'b0)) u0 (
        .UserCLK(clk), .RESET(rst), .ConfigBits(cfg), .C_bits(c0), .update_req(update_req),
        .update_ack(ack0), .changed(chg0), .rd_start(rd_start), .rd_data(d0), .rd_valid(v0),
        .rd_last(l0), .busy(b0));

    config_access_shadow #(.NoConfigBits(12), .RESET_VALUE(12'hA5A), .AUTO_UPDATE(1'b0), .MSB_FIRST(1'b1)) u1 (
        .UserCLK(clk), .RESET(rst), .ConfigBits(cfg), .C_bits(c1), .update_req(update_req),
        .update_ack(ack1), .changed(chg1), .rd_start(rd_start), .rd_data(d1), .rd_valid(v1),
        .rd_last(l1), .busy(b1));

    config_access_shadow #(.NoConfigBits(12), .RESET_VALUE(12'hA5A), .AUTO_UPDATE(1'b1), .MSB_FIRST(1'b0)) u2 (
        .UserCLK(clk), .RESET(rst), .ConfigBits(cfg2), .C_bits(c2), .update_req(1'b0),
        .update_ack(ack2), .changed(chg2), .rd_start(1'b0), .rd_data(d2), .rd_valid(v2),
        .rd_last(l2), .busy(b2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_tot++;
        $display("FAIL %s: output presented with nothing expected", name);
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back({v[i], i == 11});
            q1.push_back({v[11-i], i == 11});
        end
    endtask

    task automatic upd(input logic [11:0] v, input logic chg);
        cfg = v;
        update_req = 1'b1;
        ack_q.push_back({chg, v});
        cyc();
        update_req = 1'b0;
        chk("cbits_after_update", c0, v);
    endtask

    // Readback monitors: every presented bit must match the next scoreboard entry
    always @(negedge clk) begin
        if (v0 || l0) begin
            if (q0.size() == 0) unexpected("rb_lsb");
            else chk("rb_lsb_bit_last", {v0, d0, l0}, {1'b1, q0.pop_front()});
        end
        if (v1 || l1) begin
            if (q1.size() == 0) unexpected("rb_msb");
            else chk("rb_msb_bit_last", {v1, d1, l1}, {1'b1, q1.pop_front()});
        end
    end

    // Handshake monitor: each ack carries the expected change flag and shadow value
    always @(negedge clk) begin
        if (ack0 || chg0) begin
            if (ack_q.size() == 0) unexpected("ack");
            else begin
                logic [12:0] e;
                e = ack_q.pop_front();
                chk("ack_changed", {ack0, chg0}, {1'b1, e[12]});
                chk("ack_cbits", c0, e[11:0]);
            end
        end
    end

    // Auto-mode monitor: each change pulse must coincide with the new shadow value and no ack
    always @(negedge clk) begin
        if (chg2 || ack2) begin
            if (auto_q.size() == 0) unexpected("auto_changed");
            else begin
                chk("auto_cbits", c2, auto_q.pop_front());
                chk("auto_ack_low", ack2, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        cyc(2);
        chk("reset_cbits", c0, 12'hA5A);
        chk("reset_cbits_msb", c1, 12'hA5A);
        chk("reset_outputs", {ack0, chg0, v0, l0, b0, d0}, 0);
        rst = 1'b0;
        cyc();
        chk("idle_outputs", {ack0, chg0, v0, b0}, 0);
        chk("auto_hold", c2, 12'hA5A);

        upd(12'h123, 1'b1);
        upd(12'h123, 1'b0);
        cyc(2);

        upd(12'h00F, 1'b1);
        rd_start = 1'b1;
        push_frame(12'h00F, 12);
        cyc();
        rd_start = 1'b0;
        chk("busy_in_shift", b0, 1);
        cyc(13);
        chk("busy_after_frame", {b0, v0, b1}, 0);

        upd(12'hFFF, 1'b1);
        rd_start = 1'b1;
        push_frame(12'hFFF, 12);
        cyc();
        rd_start = 1'b0;
        cyc(3);
        upd(12'h000, 1'b1);
        cyc(12);
        chk("coherent_cbits", c0, 12'h000);

        upd(12'h5A3, 1'b1);
        rd_start = 1'b1;
        push_frame(12'h5A3, 12);
        cyc(13);
        rd_start = 1'b0;
        cyc(14);
        chk("single_frame_idle", {b0, v0}, 0);

        upd(12'h001, 1'b1);
        cfg = 12'h800;
        update_req = 1'b1;
        rd_start = 1'b1;
        ack_q.push_back({1'b1, 12'h800});
        push_frame(12'h001, 12);
        cyc();
        update_req = 1'b0;
        rd_start = 1'b0;
        chk("race_cbits", c0, 12'h800);
        cyc(14);

        rd_start = 1'b1;
        push_frame(12'h800, 5);
        cyc();
        rd_start = 1'b0;
        cyc(5);
        rst = 1'b1;
        update_req = 1'b1;
        cyc();
        update_req = 1'b0;
        chk("reset_abort_rd", {v0, l0, b0, v1, b1}, 0);
        chk("reset_abort_cbits", c0, 12'hA5A);
        rst = 1'b0;
        cyc(2);
        chk("post_reset_ack", {ack0, chg0}, 0);

        cfg2 = 12'h111;
        auto_q.push_back(12'h111);
        cyc();
        chk("auto_follow_1", c2, 12'h111);
        cyc(2);
        cfg2 = 12'h222;
        auto_q.push_back(12'h222);
        cyc();
        chk("auto_follow_2", c2, 12'h222);
        cfg2 = 12'h111;
        auto_q.push_back(12'h111);
        cyc(3);
        chk("auto_follow_3", c2, 12'h111);

        cyc(4);
        chk("rb_lsb_drained", q0.size(), 0);
        chk("rb_msb_drained", q1.size(), 0);
        chk("ack_drained", ack_q.size(), 0);
        chk("auto_drained", auto_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
